// File: rtl/fetch_stage.sv
// Fetch (F) stage of the 5-stage MIPS pipeline together with the F/D pipeline register.
//
// Holds the fetch PC (PC_F), drives it to instruction memory, flags fetch address errors,
// and selects the next PC from sequential, branch, jump, jr, eret and exception-entry sources.
//
// Ports:
//   clk     in   1   clock, all state updates on the rising edge
//   reset   in   1   asynchronous active-low reset
//   i_addr  out  32  fetch PC to instruction memory
//   i_inst  in   32  instruction word returned combinationally for i_addr
//   stall   in   1   hazard stall, holds PC_F and the F/D register
//   req     in   1   exception/interrupt taken, flush and redirect to EXC_ENTRY
//   epc     in   32  CP0 EPC, target of eret
//   eret_d  in   1   D-stage instruction is eret
//   npc_op  in   2   D-stage next-PC select: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr
//   branch  in   1   branch-taken decision for the D instruction
//   rs_d    in   32  forwarded rs value, jr target
//   pc_d    out  32  F/D: PC of the D instruction
//   inst_d  out  32  F/D: instruction word
//   bd_d    out  1   F/D: D instruction sits in a delay slot
//   exc_d   out  5   F/D: fetch exception code (0 none, 4 AdEL)
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_addr,
  input  logic [31:0] i_inst,
  input  logic        stall,
  input  logic        req,
  input  logic [31:0] epc,
  input  logic        eret_d,
  input  logic [1:0]  npc_op,
  input  logic        branch,
  input  logic [31:0] rs_d,
  output logic [31:0] pc_d,
  output logic [31:0] inst_d,
  output logic        bd_d,
  output logic [4:0]  exc_d
);

  localparam logic [1:0] NpcSeq = 2'd0;
  localparam logic [1:0] NpcBr  = 2'd1;
  localparam logic [1:0] NpcJ   = 2'd2;
  localparam logic [1:0] NpcJr  = 2'd3;

  localparam logic [4:0] ExcNone = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] inst_d_q, inst_d_d;
  logic        bd_d_q, bd_d_d;
  logic [4:0]  exc_d_q, exc_d_d;

  logic        fetch_exc;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  // Misaligned or outside the instruction memory window: the fetched word is discarded.
  assign fetch_exc = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IM_LO) || (pc_f_q > IM_HI);

  assign pc_plus4  = pc_f_q + 32'd4;
  // Branch and jump targets are relative to the instruction now in D, not to PC_F.
  assign br_target = pc_d_q + 32'd4 + {{14{inst_d_q[15]}}, inst_d_q[15:0], 2'b00};
  assign j_target  = {pc_d_q[31:28], inst_d_q[25:0], 2'b00};

  always_comb begin
    pc_f_d   = pc_f_q;
    pc_d_d   = pc_d_q;
    inst_d_d = inst_d_q;
    bd_d_d   = bd_d_q;
    exc_d_d  = exc_d_q;

    if (req) begin
      pc_f_d   = EXC_ENTRY;
      pc_d_d   = EXC_ENTRY;
      inst_d_d = 32'd0;
      bd_d_d   = 1'b0;
      exc_d_d  = ExcNone;
    end else if (stall) begin
      // hold everything; a pending redirect in D resolves once the stall drops
    end else if (eret_d) begin
      // eret has no delay slot, so the instruction fetched alongside it is squashed
      pc_f_d   = epc;
      pc_d_d   = pc_f_q;
      inst_d_d = 32'd0;
      bd_d_d   = 1'b0;
      exc_d_d  = ExcNone;
    end else begin
      pc_d_d   = pc_f_q;
      inst_d_d = fetch_exc ? 32'd0 : i_inst;
      // any control transfer in D makes the current fetch its delay slot, taken or not
      bd_d_d   = (npc_op != NpcSeq);
      exc_d_d  = fetch_exc ? ExcAdel : ExcNone;
      unique case (npc_op)
        NpcBr:   pc_f_d = branch ? br_target : pc_plus4;
        NpcJ:    pc_f_d = j_target;
        NpcJr:   pc_f_d = rs_d;
        default: pc_f_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f_q   <= PC_RESET;
      pc_d_q   <= PC_RESET;
      inst_d_q <= 32'd0;
      bd_d_q   <= 1'b0;
      exc_d_q  <= ExcNone;
    end else begin
      pc_f_q   <= pc_f_d;
      pc_d_q   <= pc_d_d;
      inst_d_q <= inst_d_d;
      bd_d_q   <= bd_d_d;
      exc_d_q  <= exc_d_d;
    end
  end

  assign i_addr = pc_f_q;
  assign pc_d   = pc_d_q;
  assign inst_d = inst_d_q;
  assign bd_d   = bd_d_q;
  assign exc_d  = exc_d_q;

endmodule
